// File: rtl/keynsham_bus_pkg.sv
// Shared definitions for the Keynsham bus decoder: FSM encoding, bus widths
// and the address-window match used by the decode logic.
package keynsham_bus_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DEFAULT
    } state_e;

    // Window sizes are powers of two with size-aligned bases, so a mask compare suffices.
    function automatic logic window_hit(input logic [ADDR_W-1:0] addr,
                                        input logic [31:0]       base,
                                        input logic [31:0]       size);
        return (({addr, 2'b00} & ~(size - 32'd1)) == base);
    endfunction

endpackage

// File: rtl/keynsham_bus_timeout.sv
// Per-transaction watchdog: saturating cycle counter with clear, enable and
// an expired flag raised while the count sits at TIMEOUT_CYCLES-1.
module keynsham_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/keynsham_bus_decoder.sv
// Single-master to N-slave decoder with registered response mux, per-access
// timeout watchdog and sticky first-fault capture.
module keynsham_bus_decoder
    import keynsham_bus_pkg::*;
#(
    parameter int           NR_SLAVES      = 8,
    parameter logic [511:0] SLAVE_BASES    = 512'h0,
    parameter logic [511:0] SLAVE_SIZES    = 512'h0,
    parameter int           TIMEOUT_CYCLES = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        m_access,
    input  logic [ADDR_W-1:0]           m_addr,
    input  logic                        m_wr_en,
    input  logic [3:0]                  m_bytesel,
    input  logic [DATA_W-1:0]           m_wr_val,
    output logic [DATA_W-1:0]           m_data,
    output logic                        m_ack,
    output logic                        m_error,
    output logic [NR_SLAVES-1:0]        s_cs,
    output logic [NR_SLAVES-1:0]        s_access,
    input  logic [NR_SLAVES-1:0]        s_ack,
    input  logic [NR_SLAVES-1:0]        s_error,
    input  logic [DATA_W*NR_SLAVES-1:0] s_data,
    output logic                        fault_valid,
    output logic [ADDR_W-1:0]           fault_addr,
    input  logic                        fault_clr
);

    state_e              state_q, state_d;
    logic [NR_SLAVES-1:0] hit, cs, sel_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic                accept, any_hit, expired;
    logic                sel_ack, sel_err;
    logic [DATA_W-1:0]   sel_data;
    logic                rsp_ack_d, rsp_err_d;
    logic [DATA_W-1:0]   rsp_data_d;
    logic                fault_evt;
    logic [ADDR_W-1:0]   fault_evt_addr;

    // Write qualifiers reach the slaves by direct wiring outside this block.
    logic unused_fwd;
    assign unused_fwd = ^{m_wr_en, m_bytesel, m_wr_val};

    // Lowest-index window wins on overlap, keeping the chip select one-hot.
    always_comb begin
        logic found;
        hit   = '0;
        cs    = '0;
        found = 1'b0;
        for (int i = 0; i < NR_SLAVES; i++) begin
            hit[i] = window_hit(m_addr, SLAVE_BASES[32*i +: 32], SLAVE_SIZES[32*i +: 32]);
            if (hit[i] && !found) begin
                cs[i] = 1'b1;
                found = 1'b1;
            end
        end
    end

    assign s_cs     = cs;
    assign any_hit  = |cs;
    assign accept   = m_access && (state_q == ST_IDLE);
    assign s_access = accept ? cs : '0;

    assign sel_ack = |(s_ack & sel_q);
    assign sel_err = |(s_error & sel_q);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NR_SLAVES; i++) begin
            if (sel_q[i]) sel_data = sel_data | s_data[32*i +: 32];
        end
    end

    keynsham_bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (state_q == ST_BUSY),
        .expired (expired)
    );

    // NOTE: every signal driven here gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    always_comb begin
        state_d        = state_q;
        rsp_ack_d      = 1'b0;
        rsp_err_d      = 1'b0;
        rsp_data_d     = '0;
        fault_evt      = 1'b0;
        fault_evt_addr = m_addr;
        case (state_q)
            ST_IDLE: begin
                if (m_access) begin
                    if (any_hit) begin
                        state_d = ST_BUSY;
                    end else begin
                        // Unmapped: the error response is registered on the way into DEFAULT.
                        state_d   = ST_DEFAULT;
                        rsp_ack_d = 1'b1;
                        rsp_err_d = 1'b1;
                        fault_evt = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (sel_ack) begin
                    state_d    = ST_IDLE;
                    rsp_ack_d  = 1'b1;
                    rsp_err_d  = sel_err;
                    rsp_data_d = sel_data;
                end else if (expired) begin
                    state_d        = ST_IDLE;
                    rsp_ack_d      = 1'b1;
                    rsp_err_d      = 1'b1;
                    fault_evt      = 1'b1;
                    fault_evt_addr = req_addr_q;
                end
            end
            ST_DEFAULT: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            req_addr_q  <= '0;
            m_ack       <= 1'b0;
            m_error     <= 1'b0;
            m_data      <= '0;
            fault_valid <= 1'b0;
            fault_addr  <= '0;
        end else begin
            state_q <= state_d;
            m_ack   <= rsp_ack_d;
            m_error <= rsp_err_d;
            m_data  <= rsp_data_d;
            if (accept && any_hit) begin
                sel_q      <= cs;
                req_addr_q <= m_addr;
            end
            // A fault arriving together with fault_clr is kept, not cleared.
            if (fault_evt && (!fault_valid || fault_clr)) begin
                fault_valid <= 1'b1;
                fault_addr  <= fault_evt_addr;
            end else if (fault_clr) begin
                fault_valid <= 1'b0;
                fault_addr  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_keynsham_bus_decoder.sv
// Bench for keynsham_bus_decoder: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_keynsham_bus_decoder;

    localparam int NR = 3;
    localparam int TO = 16;
    localparam logic [511:0] BASES = {416'h0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    localparam logic [511:0] SIZES = {416'h0, 32'h0000_0100, 32'h0000_1000, 32'h0000_1000};

    logic          clk = 1'b0;
    logic          rst;
    logic          m_access;
    logic [29:0]   m_addr;
    logic          m_wr_en;
    logic [3:0]    m_bytesel;
    logic [31:0]   m_wr_val;
    logic [31:0]   m_data;
    logic          m_ack, m_error;
    logic [NR-1:0] s_cs, s_access, s_ack, s_error;
    logic [32*NR-1:0] s_data;
    logic          fault_valid;
    logic [29:0]   fault_addr;
    logic          fault_clr;

    always #5 clk = ~clk;

    keynsham_bus_decoder #(
        .NR_SLAVES      (NR),
        .SLAVE_BASES    (BASES),
        .SLAVE_SIZES    (SIZES),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_access    (m_access),
        .m_addr      (m_addr),
        .m_wr_en     (m_wr_en),
        .m_bytesel   (m_bytesel),
        .m_wr_val    (m_wr_val),
        .m_data      (m_data),
        .m_ack       (m_ack),
        .m_error     (m_error),
        .s_cs        (s_cs),
        .s_access    (s_access),
        .s_ack       (s_ack),
        .s_error     (s_error),
        .s_data      (s_data),
        .fault_valid (fault_valid),
        .fault_addr  (fault_addr),
        .fault_clr   (fault_clr)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Address map as byte ranges [base, base+size).
    longint unsigned base_tab [NR] = '{64'h0, 64'h8000_0000, 64'h8000_0000};
    longint unsigned size_tab [NR] = '{64'h1000, 64'h1000, 64'h100};

    function automatic int decode(input logic [29:0] wa);
        longint unsigned a;
        a = {32'h0, wa, 2'b00};
        for (int i = 0; i < NR; i++) begin
            if (a >= base_tab[i] && a < base_tab[i] + size_tab[i]) return i;
        end
        return -1;
    endfunction

    // Model state: outstanding transaction, its age, and the response due next cycle.
    logic        mdl_busy, mdl_dflt, mdl_ack, mdl_err, mdl_fv;
    int          mdl_sel, mdl_wait;
    logic [29:0] mdl_addr, mdl_fa;
    logic [31:0] mdl_data;

    always @(posedge clk) begin : model
        logic        busy_n, dflt_n, ack_n, err_n, fv_n, fault_now;
        int          sel_n, wait_n, idx;
        logic [29:0] addr_n, fa_n, fault_at;
        logic [31:0] data_n;
        busy_n = mdl_busy; dflt_n = mdl_dflt; sel_n = mdl_sel; wait_n = mdl_wait;
        addr_n = mdl_addr; fv_n = mdl_fv; fa_n = mdl_fa;
        ack_n = 1'b0; err_n = 1'b0; data_n = 32'h0;
        fault_now = 1'b0; fault_at = '0;
        if (rst) begin
            busy_n = 1'b0; dflt_n = 1'b0; fv_n = 1'b0; fa_n = '0;
        end else begin
            if (mdl_dflt) begin
                dflt_n = 1'b0;
            end else if (mdl_busy) begin
                if (s_ack[mdl_sel]) begin
                    ack_n = 1'b1; err_n = s_error[mdl_sel]; data_n = s_data[32*mdl_sel +: 32];
                    busy_n = 1'b0;
                end else if (mdl_wait == TO - 1) begin
                    ack_n = 1'b1; err_n = 1'b1; fault_now = 1'b1; fault_at = mdl_addr;
                    busy_n = 1'b0;
                end else begin
                    wait_n = mdl_wait + 1;
                end
            end else if (m_access) begin
                idx = decode(m_addr);
                if (idx >= 0) begin
                    busy_n = 1'b1; sel_n = idx; wait_n = 0; addr_n = m_addr;
                end else begin
                    ack_n = 1'b1; err_n = 1'b1; dflt_n = 1'b1;
                    fault_now = 1'b1; fault_at = m_addr;
                end
            end
            if (fault_now && (!mdl_fv || fault_clr)) begin
                fv_n = 1'b1; fa_n = fault_at;
            end else if (fault_clr) begin
                fv_n = 1'b0; fa_n = '0;
            end
        end
        mdl_busy <= busy_n; mdl_dflt <= dflt_n; mdl_sel <= sel_n; mdl_wait <= wait_n;
        mdl_addr <= addr_n; mdl_fv <= fv_n; mdl_fa <= fa_n;
        mdl_ack <= ack_n; mdl_err <= err_n; mdl_data <= data_n;
    end

    always @(negedge clk) begin : compare
        int         idx;
        logic [2:0] cs;
        if (chk_en) begin
            idx = decode(m_addr);
            cs  = (idx >= 0) ? (3'b001 << idx) : 3'b000;
            check("s_cs", {29'h0, s_cs}, {29'h0, cs});
            check("s_access", {29'h0, s_access},
                  (m_access && !mdl_busy && !mdl_dflt) ? {29'h0, cs} : 32'h0);
            check("m_ack", {31'h0, m_ack}, {31'h0, mdl_ack});
            check("m_error", {31'h0, m_error}, {31'h0, mdl_err});
            check("m_data", m_data, mdl_data);
            check("fault_valid", {31'h0, fault_valid}, {31'h0, mdl_fv});
            check("fault_addr", {2'b0, fault_addr}, {2'b0, mdl_fa});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [31:0] byte_addr, input logic [2:0] exp_sacc, input string nm);
        m_access = 1'b1;
        m_addr   = byte_addr[31:2];
        @(negedge clk);
        check({nm, "_s_access"}, {29'h0, s_access}, {29'h0, exp_sacc});
        tick();
        m_access = 1'b0;
    endtask

    // Called one cycle after the access; returns at the negedge of the m_ack cycle.
    task automatic wait_ack(input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (m_ack === 1'b1) begin
                lat = c;
                return;
            end
            tick();
        end
        check("wait_ack_budget", 32'h0, 32'h1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        rst = 1'b1; m_access = 1'b0; m_addr = '0; m_wr_en = 1'b0; m_bytesel = 4'hF;
        m_wr_val = 32'h0; s_ack = '0; s_error = '0; fault_clr = 1'b0;
        s_data = {32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        check("rst_m_ack", {31'h0, m_ack}, 32'h0);
        check("rst_fault_valid", {31'h0, fault_valid}, 32'h0);
        rst = 1'b0;
        tick();

        // Read from slave1, ack three cycles after the access; an access while busy is ignored.
        access(32'h8000_0004, 3'b010, "rd1");
        m_access = 1'b1; m_addr = 30'h0;
        @(negedge clk);
        check("busy_ignore_s_access", {29'h0, s_access}, 32'h0);
        tick();
        m_access = 1'b0;
        tick();
        s_ack[1] = 1'b1;
        @(negedge clk);
        check("rd1_no_early_ack", {31'h0, m_ack}, 32'h0);
        tick();
        s_ack[1] = 1'b0;
        @(negedge clk);
        check("rd1_m_ack", {31'h0, m_ack}, 32'h1);
        check("rd1_m_data", m_data, 32'hDEAD_BEEF);
        check("rd1_m_error", {31'h0, m_error}, 32'h0);
        tick();

        // Unmapped access: error response next cycle and first fault captured.
        access(32'h4000_0000, 3'b000, "unmapped");
        @(negedge clk);
        check("unm_m_ack", {31'h0, m_ack}, 32'h1);
        check("unm_m_error", {31'h0, m_error}, 32'h1);
        check("unm_m_data", m_data, 32'h0);
        check("unm_fault_valid", {31'h0, fault_valid}, 32'h1);
        check("unm_fault_addr", {2'b0, fault_addr}, 32'h1000_0000);
        tick();

        // Slave0 never acks: forced error 17 cycles after the access, then a late ack is dropped.
        access(32'h0000_0100, 3'b001, "to");
        wait_ack(40, lat);
        check("to_latency", lat, 32'd17);
        check("to_m_error", {31'h0, m_error}, 32'h1);
        check("to_fault_kept", {2'b0, fault_addr}, 32'h1000_0000);
        tick();
        s_ack[0] = 1'b1;
        tick();
        s_ack[0] = 1'b0;
        @(negedge clk);
        check("late_ack_dropped", {31'h0, m_ack}, 32'h0);
        tick();

        // Overlapping slot2 loses to slot1; a stray ack from slot2 is ignored.
        access(32'h8000_0010, 3'b010, "ovl");
        s_ack[2] = 1'b1; s_error[2] = 1'b1;
        tick();
        s_ack[2] = 1'b0; s_error[2] = 1'b0;
        s_ack[1] = 1'b1; s_error[1] = 1'b1;
        @(negedge clk);
        check("ovl_stray_ignored", {31'h0, m_ack}, 32'h0);
        tick();
        s_ack[1] = 1'b0; s_error[1] = 1'b0;
        @(negedge clk);
        check("ovl_m_ack", {31'h0, m_ack}, 32'h1);
        check("ovl_m_error", {31'h0, m_error}, 32'h1);
        check("ovl_m_data", m_data, 32'hDEAD_BEEF);
        tick();

        // Clear the fault, then ack exactly on the expiry cycle: the ack wins.
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        @(negedge clk);
        check("clr_fault_valid", {31'h0, fault_valid}, 32'h0);
        check("clr_fault_addr", {2'b0, fault_addr}, 32'h0);
        tick();
        access(32'h0000_0000, 3'b001, "edge");
        repeat (15) tick();
        s_ack[0] = 1'b1;
        tick();
        s_ack[0] = 1'b0;
        @(negedge clk);
        check("edge_m_ack", {31'h0, m_ack}, 32'h1);
        check("edge_m_error", {31'h0, m_error}, 32'h0);
        check("edge_m_data", m_data, 32'h1111_1111);
        check("edge_fault_valid", {31'h0, fault_valid}, 32'h0);
        tick();

        // Reset during BUSY abandons the access; the following ack is dropped.
        access(32'h8000_0000, 3'b010, "rstbusy");
        tick();
        rst = 1'b1;
        m_addr = 30'h1000_0000;
        tick();
        rst = 1'b0;
        s_ack[1] = 1'b1;
        @(negedge clk);
        check("rstbusy_outputs", {m_ack, m_error, s_cs, s_access, fault_valid}, 32'h0);
        tick();
        s_ack[1] = 1'b0;
        @(negedge clk);
        check("rstbusy_no_ack", {31'h0, m_ack}, 32'h0);
        check("rstbusy_m_data", m_data, 32'h0);
        tick();

        // A fault captured in the same cycle as fault_clr wins over the clear.
        access(32'h4000_0000, 3'b000, "f1");
        tick();
        fault_clr = 1'b1;
        access(32'hC000_0000, 3'b000, "f2");
        fault_clr = 1'b0;
        @(negedge clk);
        check("capture_wins_valid", {31'h0, fault_valid}, 32'h1);
        check("capture_wins_addr", {2'b0, fault_addr}, 32'h3000_0000);
        tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        @(negedge clk);
        check("final_clr_valid", {31'h0, fault_valid}, 32'h0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/keynsham_bus_decoder.md
Name: keynsham_bus_decoder

Overview:
Parametrised single-master to N-slave bus decoder and response mux for the Keynsham data/instruction buses. It generalises fixed per-peripheral chip-select generation and the default-slave logic into one block with:
- a parameter-driven address map;
- a registered response path;
- a per-transaction timeout watchdog that terminates hung accesses with an error;
- sticky fault capture for software.
One instance sits between the CPU data port and the peripherals; a second may serve the instruction port.

Parameters:
NR_SLAVES, 8, number of slave windows (1..16).
SLAVE_BASES, 512'h0, packed NR_SLAVES x 32-bit byte base addresses; slot i at bits [32*i+31:32*i].
SLAVE_SIZES, 512'h0, packed NR_SLAVES x 32-bit window sizes in bytes; power of two, ≥4; base aligned to size.
TIMEOUT_CYCLES, 256, cycles in BUSY before forced error termination (2..65535).

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
m_access  input  1  master request strobe, one cycle per access
m_addr  input  30  master word address (byte address [31:2])
m_wr_en  input  1  write qualifier, forwarded
m_bytesel  input  4  byte lanes, forwarded
m_wr_val  input  32  write data, forwarded
m_data  output  32  read data to master
m_ack  output  1  one-cycle completion pulse
m_error  output  1  error qualifier, valid with m_ack
s_cs  output  NR_SLAVES  one-hot chip select, combinational decode of m_addr
s_access  output  NR_SLAVES  per-slave request strobe = m_access & s_cs[i] & accepted
s_ack  input  NR_SLAVES  per-slave ack pulses
s_error  input  NR_SLAVES  per-slave error, valid with ack
s_data  input  32*NR_SLAVES  per-slave read data
fault_valid  output  1  sticky: a timeout or unmapped access occurred
fault_addr  output  30  word address of first faulting access
fault_clr  input  1  clears fault_valid and fault_addr

Behaviour:
- Decode:
  - hit[i] = (({m_addr,2'b00} & ~(SIZE_i-1)) == BASE_i).
  - Overlapping windows: lowest index wins, so s_cs is strictly one-hot or zero.
- FSM states: IDLE, BUSY, DEFAULT.
- IDLE + m_access:
  - if any hit: latch sel (one-hot), go BUSY, clear timeout counter, pulse s_access[sel] in the same cycle;
  - if no hit: go DEFAULT; s_access all zero.
- DEFAULT: next cycle m_ack=1, m_error=1, m_data=0; record fault if fault_valid=0; return to IDLE. Total latency is 1 cycle after m_access.
- BUSY:
  - Counter increments each cycle.
  - On s_ack[sel]: next cycle m_ack=1, m_error=s_error[sel], m_data=s_data[sel] (registered); return to IDLE. Latency is s_ack + 1 cycle.
  - s_ack on a non-selected slave is ignored.
  - If s_ack[sel] arrives in the same cycle the counter reaches TIMEOUT_CYCLES-1, the ack wins.
  - Counter reaches TIMEOUT_CYCLES-1 without ack: next cycle m_ack=1, m_error=1, m_data=0; record fault; return to IDLE.
  - After a timeout, a late ack from that slave arriving in IDLE is dropped, with no spurious m_ack.
- m_access while not IDLE: ignored, with no s_access (protocol violation; the master must wait for m_ack).
- m_data is 0 whenever m_ack=0, so upstream OR-muxing stays legal.
- Fault capture:
  - First fault sets fault_valid and latches fault_addr; later faults do not overwrite.
  - fault_clr clears both the cycle after it is asserted.
  - Fault capture in the same cycle as fault_clr: the capture wins.
- Reset:
  - State IDLE; m_ack=0, m_error=0, m_data=0, s_access=0, fault_valid=0, fault_addr=0, counter=0.
  - Reset mid-BUSY abandons the transaction with no m_ack; a subsequent stray s_ack is dropped.
- Counter width: $clog2(TIMEOUT_CYCLES); saturating, no wrap.

Decomposition:
- Shared package keynsham_bus_pkg: FSM state encoding (IDLE/BUSY/DEFAULT), word-address width constant 30, data width 32, address-map helper function (window hit).
- One natural sub-module: keynsham_bus_timeout, the counter with clear/enable/expired outputs.
- Decode and mux stay in the top.

Test Plan:
- Map slot0 = 0x00000000/0x1000, slot1 = 0x80000000/0x1000. Read 0x80000004; slave1 acks 3 cycles later with 0xDEADBEEF -> m_ack one cycle after s_ack, m_data=0xDEADBEEF, m_error=0; only s_access[1] pulsed.
- Access 0x40000000 (unmapped) -> m_ack+m_error next cycle, m_data=0, fault_valid=1, fault_addr=0x10000000.
- TIMEOUT_CYCLES=16; slave0 never acks -> m_ack+m_error exactly 17 cycles after m_access. Then slave0 acks late -> no m_ack.
- Overlap: slot2 = 0x80000000/0x100 alongside slot1 -> access 0x80000010 selects slot1 only.
- s_ack[sel] on the expiry cycle -> normal response, m_error=s_error, fault_valid unchanged.
- Assert rst during BUSY, then slave acks -> no m_ack, all outputs 0. Pulse fault_clr after a fault -> fault_valid=0 next cycle.
